fractcam_update_ctrl: RTL and testbench
=======================================

# fractcam_update_ctrl

Sequencer that programs one entry of the fractured CAM. The CAM stores each entry as `N_SLICE` 32-deep shift-register LUTs, one per 5-bit key slice, whose match outputs feed the per-entry 6-input AND stage. On an update request the block serially shifts the 32-bit truth table of each slice into the selected entry over 32 cycles. While it does so it holds off searches, and it signals completion when the entry is consistent again.

## Interface
Parameters:
- `DEPTH`, 64: number of CAM entries; must be a multiple of 4 (AND stage slice granularity).
- `KEY_WIDTH`, 30: search key width; must equal `5*N_SLICE`.
- `N_SLICE`, 6: key slices per entry, range 1..6 (AND stage width limit).
- `IDX_W`, `$clog2(DEPTH)`: entry index width.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s_upd_valid`, in, 1: update request valid.
- `s_upd_ready`, out, 1: update request ready.
- `s_upd_index`, in, `IDX_W`: target entry.
- `s_upd_key`, in, `KEY_WIDTH`: key value.
- `s_upd_mask`, in, `KEY_WIDTH`: 1 marks a don't-care bit.
- `s_upd_del`, in, 1: 1 invalidates the entry (shifts all zeros).
- `srl_din`, out, `N_SLICE`: serial data, one bit per slice; shared by all entries.
- `srl_ce`, out, `DEPTH`: shift enable; one-hot on the target entry.
- `search_ready`, out, 1: 1 when downstream lookups may be issued.
- `upd_done`, out, 1: one-cycle pulse when the update is complete.
- `upd_err`, out, 1: qualifies `upd_done`; 1 means the index was out of range.

## Operation
States:
- **IDLE**
  - `s_upd_ready=1` and `search_ready=1`.
  - A handshake (`valid&&ready`) latches index, key, mask and del, loads `cnt=31`, and moves to SHIFT.
- **SHIFT**
  - Lasts exactly 32 cycles, with `cnt` running 31 down to 0.
  - `srl_ce[idx]=1` every SHIFT cycle; all other CE bits are 0.
  - `srl_din[s] = !del && ((cnt ^ key_s) & ~mask_s) == 0`, where `key_s`/`mask_s` are bits `[5s+4:5s]`.
  - After 32 shifts, SRL address `a` holds the bit computed at `cnt==a`.
  - On `cnt==0`, go to SETTLE.
- **SETTLE**
  - One cycle, CE all 0; covers the registered match path after the AND stage.
  - Next state is DONE.
- **DONE**
  - `upd_done=1` for one cycle; `upd_err` is valid in this cycle.
  - Next state is IDLE.

Rules:
- `s_upd_ready` and `search_ready` are both 0 in SHIFT, SETTLE and DONE.
- An index `>= DEPTH` is still accepted and runs the full sequence with `srl_ce` all 0. It then reports `upd_err=1` with `upd_done`.
- A request presented while busy is held by the requester; its inputs are not sampled until the state is IDLE.
- Fully masked slice (`mask_s=5'h1F`, not delete): all 32 bits are 1.
- Delete of an entry: all slices shift zeros, so the AND output is 0 and the entry never matches.
- Reset mid-operation: the block returns to IDLE with CE zero at the next edge. The partially shifted entry content is undefined, and software must reissue the update.
- Arithmetic: `cnt` is 5-bit unsigned and never wraps; it exits SHIFT on 0.

## Timing
- Reset values:
  - state IDLE, `cnt=0`;
  - `srl_din=0`, `srl_ce=0`;
  - `upd_done=0`, `upd_err=0`;
  - `s_upd_ready=1`, `search_ready=1` from the first cycle after reset is deasserted (both are 0 while `rst` is high).
- All outputs are registered or decoded from state only; there is no combinational path from `s_upd_*` to any output.
- Handshake at edge T:
  - SHIFT occupies cycles T+1..T+32;
  - SETTLE is T+33;
  - `upd_done` is at T+34;
  - ready returns at T+35.
- Throughput: one update per 35 cycles.

## Structure
- Shared package `fractcam_pkg` holds:
  - state encoding (IDLE, SHIFT, SETTLE, DONE);
  - `SLICE_W=5`;
  - `SRL_DEPTH=32`;
  - `MAX_SLICE=6`.
- One sub-module, `fractcam_slice_pattern`: combinational compare of `cnt` against `key_s`/`mask_s`/`del`, producing one `srl_din` bit. It is instantiated `N_SLICE` times.
- Elaboration check: `DEPTH%4==0`, `KEY_WIDTH==5*N_SLICE`, `1<=N_SLICE<=6`; any violation is an `$error`.

## Test plan
- Index 5, key slice0=5'h03, mask 0 → `srl_ce[5]` high for exactly 32 cycles; `srl_din[0]=1` only in the 29th SHIFT cycle (`cnt==3`); `upd_done` at T+34 with `upd_err=0`.
- Key slice0=5'h03, mask slice0=5'h01 → `srl_din[0]=1` at `cnt` 3 and 2 only; a slice with mask 5'h1F gives all 32 ones.
- `s_upd_del=1` on index 9 → `srl_din` is 0 for all 32 cycles, `srl_ce[9]` is pulsed 32 times.
- Index 70 with `DEPTH=64` → `srl_ce` is never asserted; `upd_done` and `upd_err` are both 1 at T+34.
- Second request held valid during busy → accepted at T+35, not earlier; `search_ready` is 0 from T+1 through T+34.
- `rst` asserted at SHIFT cycle 10 → next cycle state is IDLE, `srl_ce=0`, no `upd_done`, `s_upd_ready=1`.

Source files
------------

// File: rtl/fractcam_pkg.sv
// fractcam_pkg: shared definitions for the fractured-CAM update path.
//   state_t   : update sequencer states (IDLE, SHIFT, SETTLE, DONE)
//   SLICE_W   : key bits per SRL slice (SRL address width)
//   SRL_DEPTH : bits per slice truth table
//   MAX_SLICE : widest AND stage the entry can feed
package fractcam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SLICE_W   = 5;
  localparam int SRL_DEPTH = 32;
  localparam int MAX_SLICE = 6;
  localparam int CNT_W     = $clog2(SRL_DEPTH);

  // Truth-table bit for SRL address 'cnt': the slice matches when every
  // cared-about bit of the address equals the key. Delete forces zero.
  function automatic logic slice_bit(input logic [SLICE_W-1:0] cnt,
                                     input logic [SLICE_W-1:0] key,
                                     input logic [SLICE_W-1:0] mask,
                                     input logic               del);
    return !del && (((cnt ^ key) & ~mask) == '0);
  endfunction

endpackage

// File: rtl/fractcam_slice_pattern.sv
// fractcam_slice_pattern: one bit of serial SRL data for one key slice.
//   cnt  : current SRL address being written (shift counter)
//   key  : key bits of this slice
//   mask : don't-care bits of this slice (1 = ignore)
//   del  : entry delete; forces a zero pattern
//   din  : truth-table bit for address cnt
module fractcam_slice_pattern
  import fractcam_pkg::*;
(
  input  logic [SLICE_W-1:0] cnt,
  input  logic [SLICE_W-1:0] key,
  input  logic [SLICE_W-1:0] mask,
  input  logic               del,
  output logic               din
);

  assign din = slice_bit(cnt, key, mask, del);

endmodule

// File: rtl/fractcam_update_ctrl.sv
// fractcam_update_ctrl: serially programs one fractured-CAM entry.
// Each entry is N_SLICE 32-deep SRLs; an update shifts the 32-bit truth
// table of every slice into the target entry, then waits one cycle for the
// registered AND-stage match path before reporting completion.
//   clk, rst        : clock, synchronous active-high reset
//   s_upd_*         : update request (valid/ready, index, key, mask, del)
//   srl_din         : serial data, one bit per slice, shared by all entries
//   srl_ce          : per-entry shift enable, one-hot on target during SHIFT
//   search_ready    : lookups allowed (entry contents consistent)
//   upd_done        : one-cycle completion pulse
//   upd_err         : with upd_done, index was out of range
module fractcam_update_ctrl
  import fractcam_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int KEY_WIDTH = 30,
  parameter int N_SLICE   = 6,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_upd_valid,
  output logic                 s_upd_ready,
  input  logic [IDX_W-1:0]     s_upd_index,
  input  logic [KEY_WIDTH-1:0] s_upd_key,
  input  logic [KEY_WIDTH-1:0] s_upd_mask,
  input  logic                 s_upd_del,
  output logic [N_SLICE-1:0]   srl_din,
  output logic [DEPTH-1:0]     srl_ce,
  output logic                 search_ready,
  output logic                 upd_done,
  output logic                 upd_err
);

  // Elaboration checks
  if (DEPTH % 4 != 0) begin : g_chk_depth
    $error("fractcam_update_ctrl: DEPTH must be a multiple of 4");
  end
  if (KEY_WIDTH != SLICE_W * N_SLICE) begin : g_chk_key
    $error("fractcam_update_ctrl: KEY_WIDTH must equal 5*N_SLICE");
  end
  if (N_SLICE < 1 || N_SLICE > MAX_SLICE) begin : g_chk_slice
    $error("fractcam_update_ctrl: N_SLICE must be in 1..6");
  end

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx_q;
  logic [KEY_WIDTH-1:0] key_q, mask_q;
  logic                 del_q, err_q;
  logic                 idle, fire;
  logic [N_SLICE-1:0]   din_raw;
  logic [31:0]          idx_ext;

  assign idle    = (state == ST_IDLE);
  assign fire    = s_upd_valid && idle && !rst;
  assign idx_ext = 32'(s_upd_index);

  // Ready is a state decode; rst gates it so nothing is accepted in reset.
  assign s_upd_ready  = idle && !rst;
  assign search_ready = idle && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      key_q  <= '0;
      mask_q <= '0;
      del_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (fire) begin
        idx_q  <= s_upd_index;
        key_q  <= s_upd_key;
        mask_q <= s_upd_mask;
        del_q  <= s_upd_del;
        // Out-of-range index still runs the full sequence, just with no CE.
        err_q  <= (idx_ext >= 32'(DEPTH));
        cnt    <= CNT_W'(SRL_DEPTH - 1);
      end else if (state == ST_SHIFT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (fire) state_n = ST_SHIFT;
      ST_SHIFT:  if (cnt == '0) state_n = ST_SETTLE;
      ST_SETTLE: state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Per-slice pattern generators; cnt is the SRL address of the bit being
  // shifted now, so after 32 shifts address a holds the bit for cnt==a.
  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    fractcam_slice_pattern u_pat (
      .cnt  (cnt),
      .key  (key_q[s*SLICE_W +: SLICE_W]),
      .mask (mask_q[s*SLICE_W +: SLICE_W]),
      .del  (del_q),
      .din  (din_raw[s])
    );
  end

  // Outputs decode from state and latched request only.
  always_comb begin
    srl_din = '0;
    srl_ce  = '0;
    if (state == ST_SHIFT) begin
      srl_din = din_raw;
      if (!err_q) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (idx_q == IDX_W'(e)) srl_ce[e] = 1'b1;
        end
      end
    end
  end

  assign upd_done = (state == ST_DONE);
  assign upd_err  = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_fractcam_update_ctrl.sv
module tb_fractcam_update_ctrl;

  localparam int DEPTH = 64;
  localparam int KW    = 30;
  localparam int NS    = 6;
  localparam int IW    = 7;   // wide enough to present index 70
  localparam int NREC  = 36;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_upd_valid;
  logic           s_upd_ready;
  logic [IW-1:0]  s_upd_index;
  logic [KW-1:0]  s_upd_key;
  logic [KW-1:0]  s_upd_mask;
  logic           s_upd_del;
  logic [NS-1:0]  srl_din;
  logic [DEPTH-1:0] srl_ce;
  logic           search_ready;
  logic           upd_done;
  logic           upd_err;

  int checks   = 0;
  int failures = 0;

  // Samples k=1..NREC are taken at the k-th falling edge after handshake edge T.
  logic [NS-1:0]    din_r [1:NREC];
  logic [DEPTH-1:0] ce_r  [1:NREC];
  logic             sr_r  [1:NREC];
  logic             rdy_r [1:NREC];
  logic             done_r[1:NREC];
  logic             err_r [1:NREC];

  fractcam_update_ctrl #(.DEPTH(DEPTH), .KEY_WIDTH(KW), .N_SLICE(NS), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .s_upd_valid(s_upd_valid), .s_upd_ready(s_upd_ready),
    .s_upd_index(s_upd_index), .s_upd_key(s_upd_key),
    .s_upd_mask(s_upd_mask), .s_upd_del(s_upd_del),
    .srl_din(srl_din), .srl_ce(srl_ce), .search_ready(search_ready),
    .upd_done(upd_done), .upd_err(upd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Truth table of slice s gathered over SHIFT samples: bit a = din at cnt==a.
  function automatic logic [31:0] table_of(input int s);
    logic [31:0] t = '0;
    for (int k = 1; k <= 32; k++) t[32-k] = din_r[k][s];
    return t;
  endfunction

  function automatic int ce_hits(input int idx, input int lo, input int hi);
    logic [DEPTH-1:0] oh;
    int n = 0;
    oh = '0;
    oh[idx] = 1'b1;
    for (int k = lo; k <= hi; k++) if (ce_r[k] === oh) n++;
    return n;
  endfunction

  // Present a request, wait for the handshake edge, then record NREC samples.
  // With hold=1 a second request (idx2) stays valid right after the handshake.
  task automatic run(input logic [IW-1:0] idx, input logic [KW-1:0] key,
                     input logic [KW-1:0] mask, input logic del,
                     input bit hold, input logic [IW-1:0] idx2);
    int waitc = 0;
    @(negedge clk);
    s_upd_valid = 1'b1; s_upd_index = idx; s_upd_key = key;
    s_upd_mask = mask;  s_upd_del = del;
    while (!s_upd_ready && waitc < 100) begin @(negedge clk); waitc++; end
    if (waitc >= 100) chk("hs_timeout", 64'(waitc), 64'(0));
    @(posedge clk);
    #1;
    if (hold) begin
      s_upd_index = idx2; s_upd_key = '0; s_upd_mask = '0; s_upd_del = 1'b0;
    end else begin
      s_upd_valid = 1'b0;
    end
    for (int k = 1; k <= NREC; k++) begin
      @(negedge clk);
      din_r[k] = srl_din; ce_r[k] = srl_ce; sr_r[k] = search_ready;
      rdy_r[k] = s_upd_ready; done_r[k] = upd_done; err_r[k] = upd_err;
    end
    s_upd_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [DEPTH-1:0] acc;
    logic [63:0] oh;
    rst = 1'b1; s_upd_valid = 1'b0; s_upd_index = '0;
    s_upd_key = '0; s_upd_mask = '0; s_upd_del = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   64'(s_upd_ready), 64'(0));
    chk("rst_sready",  64'(search_ready), 64'(0));
    chk("rst_ce",      64'(srl_ce), 64'(0));
    chk("rst_din",     64'(srl_din), 64'(0));
    chk("rst_done",    64'(upd_done), 64'(0));
    chk("rst_err",     64'(upd_err), 64'(0));
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ready", 64'(s_upd_ready), 64'(1));
    chk("post_rst_sready", 64'(search_ready), 64'(1));

    // Index 5, slice0 key 3, no mask
    run(7'd5, 30'h3, 30'h0, 1'b0, 1'b0, '0);
    chk("t1_ce_shift", 64'(ce_hits(5, 1, 32)), 64'(32));
    acc = '0;
    for (int k = 33; k <= 35; k++) acc |= ce_r[k];
    chk("t1_ce_after", 64'(acc), 64'(0));
    chk("t1_tab0", 64'(table_of(0)), 64'h0000_0008);
    chk("t1_din0_k29", 64'(din_r[29][0]), 64'(1));
    chk("t1_tab1", 64'(table_of(1)), 64'h0000_0001);
    chk("t1_done33", 64'(done_r[33]), 64'(0));
    chk("t1_done34", 64'(done_r[34]), 64'(1));
    chk("t1_done35", 64'(done_r[35]), 64'(0));
    chk("t1_err34", 64'(err_r[34]), 64'(0));
    n = 0;
    for (int k = 1; k <= 34; k++) n += (sr_r[k] === 1'b0) ? 1 : 0;
    chk("t1_sready_low", 64'(n), 64'(34));
    chk("t1_ready35", 64'(rdy_r[35]), 64'(1));
    chk("t1_sready35", 64'(sr_r[35]), 64'(1));

    // Masks: slice0 key3/mask1, slice1 fully masked, slice2 key1F/mask10
    run(7'd0, 30'h0000_7C03, 30'h0000_43E1, 1'b0, 1'b0, '0);
    chk("t2_tab0", 64'(table_of(0)), 64'h0000_000C);
    chk("t2_tab1", 64'(table_of(1)), 64'hFFFF_FFFF);
    chk("t2_tab2", 64'(table_of(2)), 64'h8000_8000);
    chk("t2_tab5", 64'(table_of(5)), 64'h0000_0001);
    chk("t2_ce", 64'(ce_hits(0, 1, 32)), 64'(32));

    // Delete on index 9
    run(7'd9, 30'h3FFF_FFFF, 30'h1555_5555, 1'b1, 1'b0, '0);
    acc = '0;
    for (int k = 1; k <= 35; k++) acc[NS-1:0] |= din_r[k];
    chk("t3_din_zero", 64'(acc), 64'(0));
    chk("t3_ce_count", 64'(ce_hits(9, 1, 35)), 64'(32));
    chk("t3_done", 64'(done_r[34]), 64'(1));

    // Out-of-range index 70
    run(7'd70, 30'h3, 30'h0, 1'b0, 1'b0, '0);
    acc = '0;
    for (int k = 1; k <= 35; k++) acc |= ce_r[k];
    chk("t4_ce_none", 64'(acc), 64'(0));
    chk("t4_done34", 64'(done_r[34]), 64'(1));
    chk("t4_err34", 64'(err_r[34]), 64'(1));
    chk("t4_err33", 64'(err_r[33]), 64'(0));

    // Second request held valid while busy
    run(7'd1, 30'h0, 30'h0, 1'b0, 1'b1, 7'd2);
    chk("t5_ce_first", 64'(ce_hits(1, 1, 32)), 64'(32));
    chk("t5_ce_second_early", 64'(ce_hits(2, 1, 35)), 64'(0));
    oh = '0; oh[2] = 1'b1;
    chk("t5_ce_second_t36", 64'(ce_r[36]), oh);
    n = 0;
    for (int k = 1; k <= 34; k++) n += (sr_r[k] === 1'b0) ? 1 : 0;
    chk("t5_sready_low", 64'(n), 64'(34));
    chk("t5_rdy35", 64'(rdy_r[35]), 64'(1));
    chk("t5_rdy36", 64'(rdy_r[36]), 64'(0));
    repeat (40) @(negedge clk);
    chk("t5_idle_again", 64'(s_upd_ready), 64'(1));

    // Reset during SHIFT cycle 10
    @(negedge clk);
    s_upd_valid = 1'b1; s_upd_index = 7'd3; s_upd_key = '0;
    s_upd_mask = '0; s_upd_del = 1'b0;
    @(posedge clk); #1 s_upd_valid = 1'b0;
    repeat (10) @(negedge clk);
    oh = '0; oh[3] = 1'b1;
    chk("t6_ce_before", 64'(srl_ce), oh);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_ce_zero", 64'(srl_ce), 64'(0));
    chk("t6_din_zero", 64'(srl_din), 64'(0));
    chk("t6_no_done", 64'(upd_done), 64'(0));
    chk("t6_ready", 64'(s_upd_ready), 64'(1));
    chk("t6_sready", 64'(search_ready), 64'(1));
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n += upd_done ? 1 : 0;
    end
    chk("t6_no_late_done", 64'(n), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
